// File: rtl/vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// vga_sync_monitor
//
// Receive-side companion of the VGA timing generator. Watches a pixel-rate
// hsync/vsync pair, recovers the horizontal/vertical position counters,
// measures line length, hsync pulse width and lines per frame, and declares
// lock once LOCK_FRAMES consecutive frames match the nominal timing.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pix_en       in   pixel strobe; all state advances only when high
//   hs_in        in   horizontal sync (active level = SYNC_POL)
//   vs_in        in   vertical sync   (active level = SYNC_POL)
//   hcount       out  pixel index since last hsync leading edge (sat. 2047)
//   vcount       out  line index since frame start (sat. 2047)
//   line_len     out  last measured line length in strobes
//   hs_width     out  last measured hsync pulse width in strobes
//   frame_lines  out  last measured lines per frame
//   locked       out  stream matches nominal timing
//   err          out  one-cycle pulse on a timing violation
// ---------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 521,
  parameter int HS_WIDTH    = 96,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic [10:0] line_len,
  output logic [10:0] hs_width,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        err
);

  localparam logic [10:0] CNT_MAX    = 11'd2047;
  localparam logic [10:0] CNT_PRESAT = 11'd2046;
  localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
  localparam logic [10:0] HS_WIDTH_C = 11'(HS_WIDTH);
  // Sized for LOCK_FRAMES up to 15.
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  // Saturating increment shared by every 11-bit counter/measurement.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + 11'd1;
  endfunction

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic [10:0] wcnt_q, wcnt_d;
  logic [10:0] line_len_q, line_len_d;
  logic [10:0] hs_width_q, hs_width_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic        h_seen_q, h_seen_d;
  logic        v_seen_q, v_seen_d;
  logic        v_pend_q, v_pend_d;
  logic        frame_bad_q, frame_bad_d;
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        err_q, err_d;

  // -------------------------------------------------------------------------
  // Edge detection (qualified by the pixel strobe)
  // -------------------------------------------------------------------------
  logic hs_act, hs_q_act, vs_act, vs_q_act;
  logic hs_lead, hs_trail, vs_lead;
  logic frame_start;

  assign hs_act   = (hs_in == SYNC_POL);
  assign hs_q_act = (hs_q  == SYNC_POL);
  assign vs_act   = (vs_in == SYNC_POL);
  assign vs_q_act = (vs_q  == SYNC_POL);

  assign hs_lead  = pix_en &  hs_act & ~hs_q_act;
  assign hs_trail = pix_en & ~hs_act &  hs_q_act;
  assign vs_lead  = pix_en &  vs_act & ~vs_q_act;

  // A vs edge coinciding with the hs edge starts the frame on that same edge.
  assign frame_start = hs_lead & (v_pend_q | vs_lead);

  // -------------------------------------------------------------------------
  // Measurements and checks
  // -------------------------------------------------------------------------
  logic [10:0] line_meas;
  logic [10:0] lines_meas;
  logic        bad_line, bad_width, bad_frame, good_frame, frame_chk;
  logic        sat_hit, viol;

  assign line_meas  = sat_inc(hcount_q);
  assign lines_meas = sat_inc(vcount_q);

  assign bad_line   = hs_lead & h_seen_q & (line_meas != H_TOTAL_C);
  assign bad_width  = hs_trail & (wcnt_q != HS_WIDTH_C);
  assign frame_chk  = frame_start & v_seen_q;
  // The line closed by the frame-start edge still belongs to the old frame.
  assign bad_frame  = frame_chk & ((lines_meas != V_TOTAL_C) | frame_bad_q |
                                   bad_line | bad_width);
  assign good_frame = frame_chk & ~bad_frame;

  // hcount is about to reach 2047: fires once per missing-hsync episode
  // because hcount then sticks. An hs edge in the same strobe wins.
  assign sat_hit = pix_en & ~hs_lead & (hcount_q == CNT_PRESAT);
  assign viol    = bad_line | bad_width | bad_frame;

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    hs_d          = hs_q;
    vs_d          = vs_q;
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    wcnt_d        = wcnt_q;
    line_len_d    = line_len_q;
    hs_width_d    = hs_width_q;
    frame_lines_d = frame_lines_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    v_pend_d      = v_pend_q;
    frame_bad_d   = frame_bad_q;

    if (pix_en) begin
      hs_d = hs_in;
      vs_d = vs_in;

      hcount_d = hs_lead ? 11'd0 : sat_inc(hcount_q);

      if (hs_lead) begin
        wcnt_d = 11'd1;
      end else if (hs_act) begin
        wcnt_d = sat_inc(wcnt_q);
      end

      if (hs_trail) begin
        hs_width_d = wcnt_q;
      end

      if (hs_lead) begin
        h_seen_d = 1'b1;
        if (h_seen_q) begin
          line_len_d = line_meas;
        end
      end

      if (frame_start) begin
        vcount_d = 11'd0;
        if (v_seen_q) begin
          frame_lines_d = lines_meas;
        end
        v_seen_d = 1'b1;
        v_pend_d = 1'b0;
      end else begin
        if (hs_lead) begin
          vcount_d = sat_inc(vcount_q);
        end
        if (vs_lead) begin
          v_pend_d = 1'b1;
        end
      end

      if (frame_start) begin
        frame_bad_d = 1'b0;
      end else if (bad_line | bad_width) begin
        frame_bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      hcount_q      <= '0;
      vcount_q      <= '0;
      wcnt_q        <= '0;
      line_len_q    <= '0;
      hs_width_q    <= '0;
      frame_lines_q <= '0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      v_pend_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      wcnt_q        <= wcnt_d;
      line_len_q    <= line_len_d;
      hs_width_q    <= hs_width_d;
      frame_lines_q <= frame_lines_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      v_pend_q      <= v_pend_d;
      frame_bad_q   <= frame_bad_d;
    end
  end

  // -------------------------------------------------------------------------
  // Lock FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_UNLOCKED;
      good_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Lock FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (viol) begin
          good_cnt_d = '0;
        end else if (good_frame) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_d == LOCK_C) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (viol | sat_hit) begin
          state_d    = ST_UNLOCKED;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_UNLOCKED;
        good_cnt_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Lock FSM: outputs
  // -------------------------------------------------------------------------
  // err is gated by its own previous value so it can never stay high for two
  // consecutive cycles; viol/sat_hit are already zero when pix_en is low.
  always_comb begin
    locked = (state_q == ST_LOCKED);
    err_d  = ~err_q & (sat_hit | ((state_q == ST_LOCKED) & viol));
  end

  assign err         = err_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_len    = line_len_q;
  assign hs_width    = hs_width_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_monitor
//
// Scoreboard bench: the driver applies hs/vs strobes (with $urandom pixel
// strobe gaps), steps a timestamp-based reference model and pushes the
// expected outputs for every clock into a queue; a monitor on the falling
// edge pops and compares. Reduced timing (40x12, 6-strobe hsync) keeps
// full frames short.
// ---------------------------------------------------------------------------
module tb_vga_sync_monitor;

  localparam int H_T    = 40;
  localparam int V_T    = 12;
  localparam int HS_W   = 6;
  localparam int LOCK_N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [10:0] hcount, vcount, line_len, hs_width, frame_lines;
  logic        locked, err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_TOTAL    (H_T),
    .V_TOTAL    (V_T),
    .HS_WIDTH   (HS_W),
    .SYNC_POL   (1'b0),
    .LOCK_FRAMES(LOCK_N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hs_in      (hs_in),
    .vs_in      (vs_in),
    .hcount     (hcount),
    .vcount     (vcount),
    .line_len   (line_len),
    .hs_width   (hs_width),
    .frame_lines(frame_lines),
    .locked     (locked),
    .err        (err)
  );

  typedef struct {
    int hc; int vc; int ll; int hw; int fl; int lk; int er;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: positions derived from strobe timestamps.
  int m_n, m_tlead, m_vlines;
  int m_hc, m_vc, m_ll, m_hw, m_fl, m_lk, m_er;
  int m_good;
  bit m_hseen, m_vseen, m_vpend, m_fbad, m_prev_hs, m_prev_vs, m_err_prev;

  int gap_mode;
  int vs_off;

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_n = 0; m_tlead = 0; m_vlines = 0;
    m_hc = 0; m_vc = 0; m_ll = 0; m_hw = 0; m_fl = 0; m_lk = 0; m_er = 0;
    m_good = 0;
    m_hseen = 0; m_vseen = 0; m_vpend = 0; m_fbad = 0;
    m_prev_hs = 0; m_prev_vs = 0; m_err_prev = 0;
  endfunction

  function automatic void model_idle();
    m_er = 0;
    m_err_prev = 0;
  endfunction

  function automatic void model_step(input bit hs, input bit vs);
    bit hs_a, vs_a, lead, trail, vlead, fs;
    bit b_line, b_width, b_frame, g_frame, sat_ev, viol;
    hs_a = (hs == 1'b0);
    vs_a = (vs == 1'b0);
    lead  = hs_a && !m_prev_hs;
    trail = !hs_a && m_prev_hs;
    vlead = vs_a && !m_prev_vs;
    m_n++;
    b_line = 0; b_width = 0; b_frame = 0; g_frame = 0;
    if (trail) begin
      m_hw = sat(m_n - m_tlead);
      b_width = (m_hw != HS_W);
    end
    fs = lead && (m_vpend || vlead);
    if (lead) begin
      if (m_hseen) begin
        m_ll = sat(m_n - m_tlead);
        b_line = (m_ll != H_T);
      end
      m_hseen = 1;
      if (fs) begin
        if (m_vseen) begin
          m_fl = sat(m_vlines + 1);
          b_frame = (m_fl != V_T) || m_fbad || b_line || b_width;
          g_frame = !b_frame;
        end
        m_vlines = 0;
        m_vseen = 1;
        m_vpend = 0;
      end else begin
        m_vlines = sat(m_vlines + 1);
      end
      m_tlead = m_n;
    end else if (vlead) begin
      m_vpend = 1;
    end
    sat_ev = !lead && ((m_n - m_tlead) == 2047);
    m_hc = lead ? 0 : sat(m_n - m_tlead);
    m_vc = m_vlines;
    if (fs) m_fbad = 0;
    else if (b_line || b_width) m_fbad = 1;
    viol = b_line || b_width || b_frame;
    m_er = ((m_lk == 1 && viol) || sat_ev) && !m_err_prev;
    if (m_lk == 1) begin
      if (viol || sat_ev) begin
        m_lk = 0;
        m_good = 0;
      end
    end else begin
      if (viol) m_good = 0;
      else if (g_frame) begin
        m_good++;
        if (m_good == LOCK_N) m_lk = 1;
      end
    end
    m_err_prev = m_er;
    m_prev_hs = hs_a;
    m_prev_vs = vs_a;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.hc = m_hc; e.vc = m_vc; e.ll = m_ll; e.hw = m_hw;
    e.fl = m_fl; e.lk = m_lk; e.er = m_er;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("hcount", int'(hcount), e.hc);
        chk("vcount", int'(vcount), e.vc);
        chk("line_len", int'(line_len), e.ll);
        chk("hs_width", int'(hs_width), e.hw);
        chk("frame_lines", int'(frame_lines), e.fl);
        chk("locked", int'(locked), e.lk);
        chk("err", int'(err), e.er);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input bit en, input bit hs, input bit vs);
    @(negedge clk);
    pix_en = en;
    hs_in  = hs;
    vs_in  = vs;
    @(posedge clk);
    #1;
    if (en) model_step(hs, vs);
    else model_idle();
    push_exp();
  endtask

  task automatic strobe(input bit hs, input bit vs);
    case (gap_mode)
      0: begin
        tick(1'b0, 1'($urandom), 1'($urandom));
        tick(1'b1, hs, vs);
      end
      1: begin
        repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom), 1'($urandom));
        tick(1'b1, hs, vs);
      end
      default: tick(1'b1, hs, vs);
    endcase
  endtask

  task automatic line_seg(input int l, input int w, input int p0, input int p1);
    int pos;
    for (int p = p0; p < p1; p++) begin
      pos = l * H_T + p;
      strobe((p < w) ? 1'b0 : 1'b1,
             (pos >= vs_off && pos < vs_off + 2 * H_T) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic send_frame(input int bl, input int blen, input int bw, input int bwid);
    for (int l = 0; l < V_T; l++) begin
      line_seg(l, (l == bw) ? bwid : HS_W, 0, (l == bl) ? blen : H_T);
    end
  endtask

  task automatic nominal_frame();
    send_frame(-1, 0, -1, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    #1;
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
    chk("rst_line_len", int'(line_len), 0);
    chk("rst_hs_width", int'(hs_width), 0);
    chk("rst_frame_lines", int'(frame_lines), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    model_reset();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      push_exp();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    gap_mode = 0;
    vs_off   = 0;
    do_reset(3);

    // Nominal stream, strobe every 2nd clock: lock at the third frame start.
    nominal_frame();
    nominal_frame();
    chk("lock_not_yet", int'(locked), 0);
    nominal_frame();
    chk("lock_third_start", int'(locked), 1);
    chk("nom_line_len", int'(line_len), H_T);
    chk("nom_hs_width", int'(hs_width), HS_W);
    chk("nom_frame_lines", int'(frame_lines), V_T);
    chk("nom_hcount_end", int'(hcount), H_T - 1);
    chk("nom_vcount_end", int'(vcount), V_T - 1);

    // One short line while locked, then relock after two clean frames.
    send_frame(5, H_T - 1, -1, 0);
    chk("short_line_unlock", int'(locked), 0);
    nominal_frame();
    nominal_frame();
    chk("relock_pending", int'(locked), 0);
    nominal_frame();
    chk("relock", int'(locked), 1);

    // Missing hsync while locked.
    gap_mode = 2;
    repeat (2100) strobe(1'b1, 1'b1);
    chk("stuck_hcount", int'(hcount), 2047);
    chk("stuck_unlock", int'(locked), 0);
    gap_mode = 0;
    nominal_frame();
    nominal_frame();
    nominal_frame();
    chk("stuck_relock", int'(locked), 1);

    // Random strobe gaps: counters measured in strobes stay identical.
    gap_mode = 1;
    nominal_frame();
    nominal_frame();
    chk("gap_locked", int'(locked), 1);
    chk("gap_line_len", int'(line_len), H_T);
    chk("gap_frame_lines", int'(frame_lines), V_T);
    vs_off = 3;
    nominal_frame();
    nominal_frame();
    nominal_frame();
    vs_off   = 0;
    gap_mode = 0;

    // Reset in the middle of a line.
    for (int l = 0; l < 5; l++) line_seg(l, HS_W, 0, H_T);
    line_seg(5, HS_W, 0, 13);
    do_reset(3);
    line_seg(5, HS_W, 13, H_T);
    line_seg(6, HS_W, 0, H_T);
    chk("post_rst_first_edge", int'(line_len), 0);
    line_seg(7, HS_W, 0, H_T);
    chk("post_rst_second_edge", int'(line_len), H_T);
    for (int l = 8; l < V_T; l++) line_seg(l, HS_W, 0, H_T);

    // Narrow hsync while unlocked with one good frame counted.
    nominal_frame();
    send_frame(-1, 0, 3, HS_W - 1);
    chk("narrow_hs_width", int'(hs_width), HS_W);
    nominal_frame();
    nominal_frame();
    chk("narrow_lock_delayed", int'(locked), 0);
    nominal_frame();
    chk("narrow_relock", int'(locked), 1);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
